// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer
// Drives the PLL reconfiguration management port to move the core clock
// between three operating points: native, 60Hz underclock and bootleg.
// A mode request from another clock domain is synchronized and debounced.
// The block then writes the mode, fractional-K and start registers,
// waits for the PLL to drop lock and regain it, and reports the result.
//
// Ports:
//   clk_50m          management clock (the only clock)
//   reset            asynchronous, active-low reset
//   mode_req[1:0]    requested mode: 0 native, 1 underclock, 2 bootleg, 3 native
//   locked           PLL lock indication (asynchronous)
//   mgmt_waitrequest management port stall
//   mgmt_write       management write strobe
//   mgmt_address     management register address
//   mgmt_writedata   management register data
//   cur_mode[1:0]    mode written by the last completed sequence
//   busy             high while a sequence is in progress
//   done             one-cycle pulse when a sequence completes
//   lock_err         sticky flag: PLL failed to relock in time
module pll_reconfig_sequencer #(
  parameter logic [31:0] K_NATIVE      = 32'd3639383488,
  parameter logic [31:0] K_UNDER       = 32'd2971430088,
  parameter logic [31:0] K_BOOT        = 32'd2748778984,
  parameter int          STABLE_CYCLES = 16,
  parameter int          GAP_CYCLES    = 3,
  parameter int          UNLOCK_WAIT   = 256,
  parameter int          LOCK_TIMEOUT  = 1048576
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic [1:0]  mode_req,
  input  logic        locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic [1:0]  cur_mode,
  output logic        busy,
  output logic        done,
  output logic        lock_err
);

  localparam int SW    = $clog2(STABLE_CYCLES + 1);
  localparam int TMAX0 = (GAP_CYCLES > UNLOCK_WAIT) ? GAP_CYCLES : UNLOCK_WAIT;
  localparam int TMAX  = (TMAX0 > LOCK_TIMEOUT) ? TMAX0 : LOCK_TIMEOUT;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_WAIT - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_MODE,
    S_GAP_MODE,
    S_WR_FRAC,
    S_GAP_FRAC,
    S_WR_START,
    S_WAIT_UNLOCK,
    S_WAIT_LOCK,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [1:0]    mode_meta, mode_sync;
  logic          lock_meta, lock_sync;
  logic [1:0]    req_mapped, req_val;
  logic [SW-1:0] stab_cnt;
  logic          stable;
  logic [TW-1:0] timer;
  logic [1:0]    tgt;
  logic [31:0]   frac_word;
  logic          start_seq, lock_ok, lock_to;

  // Two-flop synchronizers for the asynchronous request and lock inputs.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      mode_meta <= 2'd0;
      mode_sync <= 2'd0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      mode_meta <= mode_req;
      mode_sync <= mode_meta;
      lock_meta <= locked;
      lock_sync <= lock_meta;
    end
  end

  // Request value 3 has no operating point of its own and means native.
  assign req_mapped = (mode_sync == 2'd3) ? 2'd0 : mode_sync;
  assign stable     = (stab_cnt == STABLE_MAX);

  // Debounce: any change restarts the count; the count saturates once stable.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      req_val  <= 2'd0;
      stab_cnt <= '0;
    end else if (req_mapped != req_val) begin
      req_val  <= req_mapped;
      stab_cnt <= '0;
    end else if (!stable) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  always_comb begin
    case (tgt)
      2'd1:    frac_word = K_UNDER;
      2'd2:    frac_word = K_BOOT;
      default: frac_word = K_NATIVE;
    endcase
  end

  // Next-state and port outputs. A write state holds the strobe until the
  // port accepts it; the following gap state drops the strobe.
  always_comb begin
    state_next     = state;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    busy           = 1'b1;
    done           = 1'b0;
    start_seq      = 1'b0;
    lock_ok        = 1'b0;
    lock_to        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (stable && (req_val != cur_mode)) begin
          start_seq  = 1'b1;
          state_next = S_WR_MODE;
        end
      end
      S_WR_MODE: begin
        mgmt_write = 1'b1;
        if (!mgmt_waitrequest) state_next = S_GAP_MODE;
      end
      S_GAP_MODE: begin
        if (timer == GAP_LAST) state_next = S_WR_FRAC;
      end
      S_WR_FRAC: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd7;
        mgmt_writedata = frac_word;
        if (!mgmt_waitrequest) state_next = S_GAP_FRAC;
      end
      S_GAP_FRAC: begin
        if (timer == GAP_LAST) state_next = S_WR_START;
      end
      S_WR_START: begin
        mgmt_write   = 1'b1;
        mgmt_address = 6'd2;
        if (!mgmt_waitrequest) state_next = S_WAIT_UNLOCK;
      end
      S_WAIT_UNLOCK: begin
        // A PLL that never visibly drops lock is not an error.
        if (!lock_sync || (timer == UNLOCK_LAST)) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_sync) begin
          lock_ok    = 1'b1;
          state_next = S_DONE;
        end else if (timer == LOCK_LAST) begin
          lock_to    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // State register, shared timer (cleared on every state entry) and the
  // sequence results.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      tgt      <= 2'd0;
      cur_mode <= 2'd0;
      lock_err <= 1'b0;
    end else begin
      state <= state_next;
      timer <= (state_next != state) ? '0 : timer + 1'b1;
      if (start_seq)        tgt      <= req_val;
      if (state == S_DONE)  cur_mode <= tgt;
      if (lock_ok)          lock_err <= 1'b0;
      else if (lock_to)     lock_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// tb_pll_reconfig_sequencer
// Directed bench for pll_reconfig_sequencer. Expected management writes are
// queued when a request is driven and popped as the port accepts them. A
// PLL model in the monitor drops and regains lock after each start write.
module tb_pll_reconfig_sequencer;

  localparam logic [31:0] K_NATIVE = 32'd3639383488;
  localparam logic [31:0] K_UNDER  = 32'd2971430088;
  localparam logic [31:0] K_BOOT   = 32'd2748778984;

  logic        clk_50m = 1'b0;
  logic        reset;
  logic [1:0]  mode_req;
  logic        locked;
  logic        mgmt_waitrequest;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [1:0]  cur_mode;
  logic        busy;
  logic        done;
  logic        lock_err;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          width;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  failures = 0;
  int  write_cnt = 0;
  int  done_cnt = 0;
  int  unexpected = 0;
  int  pll_mode = 0;  // 0: always locked, 1: drop then relock, 2: drop forever

  pll_reconfig_sequencer #(.LOCK_TIMEOUT(64)) dut (
    .clk_50m          (clk_50m),
    .reset            (reset),
    .mode_req         (mode_req),
    .locked           (locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .cur_mode         (cur_mode),
    .busy             (busy),
    .done             (done),
    .lock_err         (lock_err)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic push_write(input logic [5:0] a, input logic [31:0] d, input int w);
    wr_t e;
    e.addr  = a;
    e.data  = d;
    e.width = w;
    exp_q.push_back(e);
  endtask

  task automatic push_sequence(input logic [31:0] k, input int frac_width);
    push_write(6'd0, 32'd0, 1);
    push_write(6'd7, k, frac_width);
    push_write(6'd2, 32'd0, 1);
  endtask

  task automatic apply_stimulus(input logic [1:0] m);
    @(posedge clk_50m);
    #1 mode_req = m;
  endtask

  // Returns at the falling edge where done is high, or after the budget.
  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_50m);
      if (done === 1'b1) seen = 1'b1;
    end
    check_output({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_write_addr(input string tag, input logic [5:0] a, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_50m);
      if (mgmt_write === 1'b1 && mgmt_address === a) seen = 1'b1;
    end
    check_output({tag, "_write_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_after_done(input string tag, input logic [1:0] mode,
                                  input logic err);
    check_output({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk_50m);
    check_output({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check_output({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    check_output({tag, "_cur_mode"}, {30'd0, cur_mode}, {30'd0, mode});
    check_output({tag, "_lock_err"}, {31'd0, lock_err}, {31'd0, err});
    check_output({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    check_output({tag, "_unexpected"}, unexpected, 32'd0);
  endtask

  // Monitor, scoreboard and PLL model, all sampled on the falling edge.
  initial begin
    logic        prev_write = 1'b0;
    logic        prev_done  = 1'b0;
    logic [5:0]  prev_addr  = 6'd0;
    logic [31:0] prev_data  = 32'd0;
    int          high_run   = 0;
    int          idle_run   = 100;
    int          unlock_cnt = 0;
    int          relock_cnt = 0;
    wr_t         e;
    locked = 1'b1;
    forever begin
      @(negedge clk_50m);
      if (mgmt_write === 1'b1) begin
        if (prev_write) begin
          check_output("hold_addr", {26'd0, mgmt_address}, {26'd0, prev_addr});
          check_output("hold_data", mgmt_writedata, prev_data);
        end else begin
          check_output("write_gap", {31'd0, (idle_run >= 3)}, 32'd1);
        end
        idle_run = 0;
        high_run++;
        if (mgmt_waitrequest === 1'b0) begin
          write_cnt++;
          if (exp_q.size() == 0) begin
            unexpected++;
          end else begin
            e = exp_q.pop_front();
            check_output("write_addr", {26'd0, mgmt_address}, {26'd0, e.addr});
            check_output("write_data", mgmt_writedata, e.data);
            check_output("write_width", high_run, e.width);
          end
          if (mgmt_address == 6'd2 && pll_mode != 0) unlock_cnt = 5;
        end
      end else begin
        idle_run++;
        high_run = 0;
      end
      prev_write = mgmt_write;
      prev_addr  = mgmt_address;
      prev_data  = mgmt_writedata;

      if (done === 1'b1) begin
        check_output("done_width", {31'd0, prev_done}, 32'd0);
        done_cnt++;
      end
      prev_done = done;

      if (pll_mode == 0) locked = 1'b1;
      if (unlock_cnt > 0) begin
        unlock_cnt--;
        if (unlock_cnt == 0) begin
          locked = 1'b0;
          if (pll_mode == 1) relock_cnt = 50;
        end
      end else if (relock_cnt > 0) begin
        relock_cnt--;
        if (relock_cnt == 0) locked = 1'b1;
      end
    end
  end

  initial begin
    reset            = 1'b0;
    mode_req         = 2'd0;
    mgmt_waitrequest = 1'b0;

    // Outputs while held in reset.
    repeat (3) @(negedge clk_50m);
    check_output("rst_write", {31'd0, mgmt_write}, 32'd0);
    check_output("rst_addr", {26'd0, mgmt_address}, 32'd0);
    check_output("rst_data", mgmt_writedata, 32'd0);
    check_output("rst_cur_mode", {30'd0, cur_mode}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_lock_err", {31'd0, lock_err}, 32'd0);
    @(posedge clk_50m);
    #1 reset = 1'b1;

    // Native request after power-on: nothing to do.
    repeat (100) @(negedge clk_50m);
    check_output("idle_writes", write_cnt, 32'd0);
    check_output("idle_done", done_cnt, 32'd0);
    check_output("idle_busy", {31'd0, busy}, 32'd0);
    check_output("idle_cur_mode", {30'd0, cur_mode}, 32'd0);

    // Short glitch must be filtered out.
    apply_stimulus(2'd1);
    repeat (3) @(posedge clk_50m);
    #1 mode_req = 2'd0;
    repeat (60) @(negedge clk_50m);
    check_output("glitch_writes", write_cnt, 32'd0);
    check_output("glitch_busy", {31'd0, busy}, 32'd0);

    // Native to underclock with a normal relock.
    pll_mode = 1;
    push_sequence(K_UNDER, 1);
    apply_stimulus(2'd1);
    wait_done("under", 400);
    check_after_done("under", 2'd1, 1'b0);
    check_output("under_writes", write_cnt, 32'd3);

    // Bootleg with the fractional write stalled for 10 cycles.
    push_sequence(K_BOOT, 11);
    apply_stimulus(2'd2);
    wait_write_addr("stall_mode", 6'd0, 100);
    @(posedge clk_50m);
    #1 mgmt_waitrequest = 1'b1;
    wait_write_addr("stall_frac", 6'd7, 100);
    repeat (9) @(negedge clk_50m);
    @(posedge clk_50m);
    #1 mgmt_waitrequest = 1'b0;
    wait_done("boot", 400);
    check_after_done("boot", 2'd2, 1'b0);

    // New request arriving during relock runs as a second sequence.
    push_sequence(K_UNDER, 1);
    push_sequence(K_BOOT, 1);
    apply_stimulus(2'd1);
    for (int i = 0; i < 200 && locked !== 1'b0; i++) @(negedge clk_50m);
    check_output("late_unlock_seen", {31'd0, locked}, 32'd0);
    repeat (4) @(negedge clk_50m);
    apply_stimulus(2'd2);
    wait_done("late_first", 400);
    check_output("late_first_busy", {31'd0, busy}, 32'd1);
    @(negedge clk_50m);
    check_output("late_first_mode", {30'd0, cur_mode}, 32'd1);
    wait_done("late_second", 400);
    check_after_done("late_second", 2'd2, 1'b0);

    // PLL never relocks: timeout sets the sticky error.
    pll_mode = 2;
    push_sequence(K_NATIVE, 1);
    apply_stimulus(2'd0);
    wait_done("timeout", 400);
    check_output("timeout_err_in_done", {31'd0, lock_err}, 32'd1);
    check_after_done("timeout", 2'd0, 1'b1);
    @(posedge clk_50m);
    #1 pll_mode = 0;
    repeat (5) @(negedge clk_50m);
    check_output("timeout_err_sticky", {31'd0, lock_err}, 32'd1);

    // A successful sequence clears the error.
    pll_mode = 1;
    push_sequence(K_UNDER, 1);
    apply_stimulus(2'd1);
    wait_done("recover", 400);
    check_after_done("recover", 2'd1, 1'b0);

    // Reset while the fractional write is stalled, then a clean rerun.
    pll_mode = 0;
    push_write(6'd0, 32'd0, 1);
    apply_stimulus(2'd2);
    wait_write_addr("abort_mode", 6'd0, 100);
    @(posedge clk_50m);
    #1 mgmt_waitrequest = 1'b1;
    wait_write_addr("abort_frac", 6'd7, 100);
    repeat (3) @(negedge clk_50m);
    check_output("abort_stall_write", {31'd0, mgmt_write}, 32'd1);
    check_output("abort_stall_data", mgmt_writedata, K_BOOT);
    @(posedge clk_50m);
    #1 mode_req = 2'd1;
    #2 reset = 1'b0;
    #1;
    check_output("abort_write", {31'd0, mgmt_write}, 32'd0);
    check_output("abort_addr", {26'd0, mgmt_address}, 32'd0);
    check_output("abort_data", mgmt_writedata, 32'd0);
    check_output("abort_cur_mode", {30'd0, cur_mode}, 32'd0);
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort_done", {31'd0, done}, 32'd0);
    check_output("abort_lock_err", {31'd0, lock_err}, 32'd0);
    check_output("abort_queue", exp_q.size(), 32'd0);
    mgmt_waitrequest = 1'b0;
    push_sequence(K_UNDER, 1);
    repeat (3) @(posedge clk_50m);
    #1 reset = 1'b1;
    wait_done("rerun", 700);
    check_after_done("rerun", 2'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_sequencer.md
Name: pll_reconfig_sequencer

Overview:
- Owns the PLL reconfiguration management port and selects the core clock operating point: native, 60Hz underclock or bootleg.
- Accepts a mode request from the core clock domain, synchronizes and debounces it, then issues the mode/fractional/start write sequence with waitrequest handshaking.
- Supervises PLL relock and reports current mode, busy, done and lock-timeout error.
- Sits between status/ROM-header decode and pll_cfg, and replaces ad-hoc step counters.

Parameters:
- K_NATIVE, 3639383488, fractional-K word for native clock.
- K_UNDER, 2971430088, fractional-K word for 60Hz-adjust underclock.
- K_BOOT, 2748778984, fractional-K word for bootleg PCB clock.
- STABLE_CYCLES, 16, consecutive cycles a synchronized request must hold before it is acted on.
- GAP_CYCLES, 3, idle cycles inserted after each accepted write.
- UNLOCK_WAIT, 256, maximum cycles to observe locked falling after the start write.
- LOCK_TIMEOUT, 1048576, maximum cycles to wait for locked rising.

Ports:
- clk_50m  in  1  management clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- mode_req  in  2  0=native, 1=underclock, 2=bootleg, 3=treated as native; asynchronous to clk_50m.
- locked  in  1  PLL locked; asynchronous.
- mgmt_waitrequest  in  1  management port busy.
- mgmt_write  out  1  write strobe.
- mgmt_address  out  6  register address.
- mgmt_writedata  out  32  register data.
- cur_mode  out  2  last mode written.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- lock_err  out  1  sticky lock-timeout flag.

Behaviour:
- Reset (asynchronous, active-low) puts all outputs to 0: mgmt_write=0, mgmt_address=0, mgmt_writedata=0, cur_mode=0, busy=0, done=0, lock_err=0. State returns to IDLE and all counters clear.
- Any sequence in flight when reset is asserted is abandoned immediately.
- Power-on PLL state is native. If mode_req≠0 after reset, a sequence runs once the request is stable.
- mode_req passes through a 2-FF synchronizer. Value 3 maps to 0 after synchronization.
- The stability counter resets on any change of the synchronized value. The request is "stable" once the counter reaches STABLE_CYCLES, and the counter saturates there.
- locked passes through a 2-FF synchronizer. All lock tests below use the synchronized value.
- Write handshake:
  - In a write state, drive mgmt_write=1 with address and data held constant.
  - The write is accepted on the first clk_50m edge where mgmt_write=1 and mgmt_waitrequest=0.
  - Drop mgmt_write in the following cycle, then wait GAP_CYCLES before the next write.
  - mgmt_write is never asserted in non-write states.
- States:
  - IDLE: busy=0. If stable target≠cur_mode, latch target into tgt, set busy=1, go to WR_MODE.
  - WR_MODE: address 0, data 0 (waitrequest mode). On accept, then gap, go to WR_FRAC.
  - WR_FRAC: address 7, data = K_NATIVE, K_UNDER or K_BOOT according to tgt. On accept, then gap, go to WR_START.
  - WR_START: address 2, data 0. On accept, go to WAIT_UNLOCK.
  - WAIT_UNLOCK: go to WAIT_LOCK when locked=0, or after UNLOCK_WAIT cycles (no error in the timeout case).
  - WAIT_LOCK: when locked=1, clear lock_err and go to DONE. After LOCK_TIMEOUT cycles, set lock_err=1 and go to DONE.
  - DONE: cur_mode<=tgt, pulse done for one cycle, busy=0 on the next cycle, return to IDLE.
- Request changes during a sequence are not applied mid-sequence; tgt stays frozen. After DONE, IDLE compares the stable request against cur_mode and starts a new sequence if they differ. Net effect: last request wins, with at most one extra sequence.
- mgmt_waitrequest held high indefinitely stalls in the current write state with no timeout. Only reset recovers.
- Counter widths: enough bits for each parameter's value. The gap, unlock and lock counters clear on every state entry.

Test Plan:
- Reset with mode_req=0 and locked=1 for 100 cycles → no mgmt_write, busy=0, cur_mode=0, done never pulses.
- mode_req 0→1, waitrequest=0, locked drops 5 cycles after the start write and rises 50 cycles later → exactly three writes, in order: (0,0), (7,2971430088), (2,0). Each write is one cycle wide, separated by at least 3 idle cycles. Then a done pulse, cur_mode=1, lock_err=0.
- mode_req=2 with waitrequest high for 10 cycles during WR_FRAC → mgmt_write stays high with address 7, data 2748778984 for 11 cycles, accepted once; sequence completes with cur_mode=2.
- mode_req glitches 0→1→0 within 8 cycles → no sequence starts. Separately, change 1→2 during WAIT_LOCK → first sequence finishes with cur_mode=1, then a second sequence writes K_BOOT and ends with cur_mode=2.
- locked never returns after the start write (LOCK_TIMEOUT reduced to 64) → lock_err=1 and a done pulse. A subsequent successful reconfiguration clears lock_err.
- Reset asserted in WR_FRAC while mgmt_write=1 → mgmt_write=0 asynchronously and all outputs return to 0. After release with mode_req=1 held, a full sequence reruns starting at address 0.
